// File: rtl/talanquera_ctrl.sv
// Exit-barrier sequencer: queues paid exit grants from the payment FSM and runs the
// barrier motor through open / wait-for-vehicle / confirm-clear / close, reopening on obstruction.
module talanquera_ctrl #(
  parameter int unsigned OPEN_CYCLES  = 8,
  parameter int unsigned CLOSE_CYCLES = 8,
  parameter int unsigned PASS_TIMEOUT = 64,
  parameter int unsigned CLEAR_HOLD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pago_ok,
  input  logic       sensor,
  output logic       motor_abrir,
  output logic       motor_cerrar,
  output logic       talanquera,
  output logic [1:0] pendientes,
  output logic       desborde,
  output logic       timeout,
  output logic       reabre,
  output logic [7:0] salidas,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OPENING    = 3'd1,
    OPEN_WAIT  = 3'd2,
    PASSING    = 3'd3,
    CLEAR_WAIT = 3'd4,
    CLOSING    = 3'd5
  } state_t;

  // The timer counts cycles already spent in the current state, so each limit is N-1.
  localparam logic [7:0] OPEN_LAST  = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] CLOSE_LAST = 8'(CLOSE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST  = 8'(PASS_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CLEAR_HOLD - 1);

  state_t     state, next_state;
  logic [7:0] timer;
  logic       consume, timeout_evt, reabre_evt, exit_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state)
        timer <= 8'd0;
      else if (timer != 8'hFF)
        timer <= timer + 8'd1;
    end
  end

  always_comb begin
    next_state  = state;
    consume     = 1'b0;
    timeout_evt = 1'b0;
    reabre_evt  = 1'b0;
    exit_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (pago_ok || pendientes != 2'd0) begin
          next_state = OPENING;
          consume    = 1'b1;
        end
      end
      OPENING:
        if (timer == OPEN_LAST) next_state = OPEN_WAIT;
      OPEN_WAIT: begin
        if (!sensor) begin
          next_state = PASSING;
        end else if (timer == PASS_LAST) begin
          next_state  = CLOSING;
          timeout_evt = 1'b1;
        end
      end
      PASSING:
        if (sensor) next_state = CLEAR_WAIT;
      CLEAR_WAIT: begin
        if (!sensor) begin
          next_state = PASSING;
        end else if (timer == HOLD_LAST) begin
          next_state = CLOSING;
          exit_evt   = 1'b1;
        end
      end
      CLOSING: begin
        // An obstruction always wins, even on the last closing cycle.
        if (!sensor) begin
          next_state = OPENING;
          reabre_evt = 1'b1;
        end else if (timer == CLOSE_LAST) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A pago_ok arriving on the same edge a grant is consumed cancels out instead of dropping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendientes <= 2'd0;
      salidas    <= 8'd0;
      desborde   <= 1'b0;
      timeout    <= 1'b0;
      reabre     <= 1'b0;
    end else begin
      if (consume) begin
        if (!pago_ok) pendientes <= pendientes - 2'd1;
      end else if (pago_ok && pendientes != 2'd3) begin
        pendientes <= pendientes + 2'd1;
      end
      desborde <= pago_ok && !consume && (pendientes == 2'd3);
      timeout  <= timeout_evt;
      reabre   <= reabre_evt;
      if (exit_evt) salidas <= salidas + 8'd1;
    end
  end

  always_comb begin
    motor_abrir  = (state == OPENING);
    motor_cerrar = (state == CLOSING);
    talanquera   = (state == OPEN_WAIT) || (state == PASSING) || (state == CLEAR_WAIT);
    estado       = state;
  end

endmodule

// File: tb/tb_talanquera_ctrl.sv
// Self-checking bench for talanquera_ctrl: directed scenarios with hand-computed cycle
// expectations, then randomized traffic checked every cycle against a countdown-style model.
module tb_talanquera_ctrl;

  localparam int OPEN_CYCLES  = 8;
  localparam int CLOSE_CYCLES = 8;
  localparam int PASS_TIMEOUT = 64;
  localparam int CLEAR_HOLD   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pago_ok;
  logic       sensor;
  logic       motor_abrir, motor_cerrar, talanquera, desborde, timeout, reabre;
  logic [1:0] pendientes;
  logic [7:0] salidas;
  logic [2:0] estado;

  int vectors = 0;
  int miscompares = 0;
  bit model_on = 1'b0;

  // Model state: phase number, cycles left in timed phases, consecutive-count, grants, exits.
  int m_phase, m_left, m_count, m_pend, m_exits;
  bit m_desb, m_tmo, m_reab;

  talanquera_ctrl #(
    .OPEN_CYCLES (OPEN_CYCLES),
    .CLOSE_CYCLES(CLOSE_CYCLES),
    .PASS_TIMEOUT(PASS_TIMEOUT),
    .CLEAR_HOLD  (CLEAR_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pago_ok     (pago_ok),
    .sensor      (sensor),
    .motor_abrir (motor_abrir),
    .motor_cerrar(motor_cerrar),
    .talanquera  (talanquera),
    .pendientes  (pendientes),
    .desborde    (desborde),
    .timeout     (timeout),
    .reabre      (reabre),
    .salidas     (salidas),
    .estado      (estado)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: each phase tracks how many cycles it still owes rather than an up-timer.
  always @(posedge clk or posedge reset) begin : model
    int p, left, cnt, pend, exits;
    bit desb, tmo, reab, take;
    if (reset) begin
      m_phase <= 0; m_left <= 0; m_count <= 0; m_pend <= 0; m_exits <= 0;
      m_desb <= 1'b0; m_tmo <= 1'b0; m_reab <= 1'b0;
    end else begin
      p = m_phase; left = m_left; cnt = m_count; pend = m_pend; exits = m_exits;
      desb = 1'b0; tmo = 1'b0; reab = 1'b0;
      take = (p == 0) && (pago_ok || pend > 0);
      case (p)
        0: if (take) begin p = 1; left = OPEN_CYCLES; end
        1: begin left--; if (left == 0) begin p = 2; cnt = 0; end end
        2: if (!sensor) p = 3;
           else begin
             cnt++;
             if (cnt == PASS_TIMEOUT) begin p = 5; left = CLOSE_CYCLES; tmo = 1'b1; end
           end
        3: if (sensor) begin p = 4; cnt = 0; end
        4: if (!sensor) p = 3;
           else begin
             cnt++;
             if (cnt == CLEAR_HOLD) begin p = 5; left = CLOSE_CYCLES; exits = (exits + 1) % 256; end
           end
        5: if (!sensor) begin p = 1; left = OPEN_CYCLES; reab = 1'b1; end
           else begin left--; if (left == 0) p = 0; end
        default: p = 0;
      endcase
      if (take) begin
        if (!pago_ok) pend--;
      end else if (pago_ok) begin
        if (pend == 3) desb = 1'b1;
        else pend++;
      end
      m_phase <= p; m_left <= left; m_count <= cnt; m_pend <= pend; m_exits <= exits;
      m_desb <= desb; m_tmo <= tmo; m_reab <= reab;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_output("estado",       8'(estado),       8'(m_phase));
      check_output("motor_abrir",  8'(motor_abrir),  8'(m_phase == 1));
      check_output("motor_cerrar", 8'(motor_cerrar), 8'(m_phase == 5));
      check_output("talanquera",   8'(talanquera),   8'(m_phase >= 2 && m_phase <= 4));
      check_output("pendientes",   8'(pendientes),   8'(m_pend));
      check_output("desborde",     8'(desborde),     8'(m_desb));
      check_output("timeout",      8'(timeout),      8'(m_tmo));
      check_output("reabre",       8'(reabre),       8'(m_reab));
      check_output("salidas",      salidas,          8'(m_exits));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    pago_ok = 1'b0;
    sensor  = 1'b1;
    reset   = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Grant at cycle 0 with a clear lane; returns at cycle 9 (first OPEN_WAIT cycle).
  task automatic open_once();
    pago_ok = 1'b1;
    tick();
    pago_ok = 1'b0;
    check_output("t1_abrir_c1", 8'(motor_abrir), 8'd1);
    check_output("t1_pend_c1",  8'(pendientes),  8'd0);
    tick(7);
    check_output("t1_abrir_c8", 8'(motor_abrir), 8'd1);
    tick();
    check_output("t1_abrir_c9", 8'(motor_abrir), 8'd0);
    check_output("t1_tal_c9",   8'(talanquera),  8'd1);
    check_output("t1_estado_c9", 8'(estado),     8'd2);
  endtask

  task automatic apply_stimulus(input int cycles);
    int run_left = 0;
    for (int i = 0; i < cycles; i++) begin
      pago_ok = ($urandom_range(0, 15) == 0);
      if (run_left == 0) begin
        sensor   = ($urandom_range(0, 2) != 0);
        run_left = sensor ? $urandom_range(1, 90) : $urandom_range(1, 8);
      end
      run_left--;
      tick();
    end
    pago_ok = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    pago_ok = 1'b0;
    sensor  = 1'b1;
    tick();
    model_on = 1'b1;
    do_reset();
    check_output("rst_estado",  8'(estado),      8'd0);
    check_output("rst_salidas", salidas,         8'd0);
    check_output("rst_pend",    8'(pendientes),  8'd0);

    // Vehicle passes: sensor low cycles 9..13, clear from 14.
    open_once();
    sensor = 1'b0;
    tick(5);
    check_output("t2_passing", 8'(estado), 8'd3);
    sensor = 1'b1;
    tick();
    check_output("t2_hold_c15", 8'(estado), 8'd4);
    tick(3);
    check_output("t2_hold_c18", 8'(estado), 8'd4);
    tick();
    check_output("t2_close_c19", 8'(motor_cerrar), 8'd1);
    check_output("t2_salidas",   salidas,          8'd1);
    tick(7);
    check_output("t2_close_c26", 8'(motor_cerrar), 8'd1);
    tick();
    check_output("t2_idle_c27", 8'(estado), 8'd0);

    // No vehicle: OPEN_WAIT cycles 9..72, timeout visible in cycle 73.
    open_once();
    tick(63);
    check_output("t3_wait_c72", 8'(estado), 8'd2);
    check_output("t3_tmo_c72",  8'(timeout), 8'd0);
    tick();
    check_output("t3_tmo_c73",  8'(timeout), 8'd1);
    check_output("t3_cerrar",   8'(motor_cerrar), 8'd1);
    check_output("t3_salidas",  salidas, 8'd1);
    tick();
    check_output("t3_tmo_c74",  8'(timeout), 8'd0);
    tick(7);
    check_output("t3_idle_c81", 8'(estado), 8'd0);

    // Obstruction in the third closing cycle (cycle 75).
    open_once();
    tick(66);
    check_output("t4_closing_c75", 8'(estado), 8'd5);
    sensor = 1'b0;
    tick();
    sensor = 1'b1;
    check_output("t4_reabre",  8'(reabre),       8'd1);
    check_output("t4_cerrar",  8'(motor_cerrar), 8'd0);
    check_output("t4_abrir",   8'(motor_abrir),  8'd1);
    check_output("t4_pend",    8'(pendientes),   8'd0);
    tick(7);
    check_output("t4_abrir_8th", 8'(motor_abrir), 8'd1);
    check_output("t4_reabre_off", 8'(reabre),     8'd0);
    do_reset();

    // Four grants during OPENING (cycles 1,3,5,7): queue saturates, fourth overflows.
    pago_ok = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      pago_ok = 1'b1;
      tick();
      pago_ok = 1'b0;
      tick();
    end
    check_output("t5_desborde_c9", 8'(desborde), 8'd0);
    check_output("t5_pend_c9",     8'(pendientes), 8'd3);
    tick(72);
    check_output("t5_pend_c81",    8'(pendientes), 8'd3);
    tick();
    check_output("t5_pend_c82",    8'(pendientes), 8'd2);
    check_output("t5_open_c82",    8'(estado),     8'd1);
    tick(250);
    check_output("t5_pend_end",    8'(pendientes), 8'd0);
    check_output("t5_idle_end",    8'(estado),     8'd0);

    // Reset mid-OPENING: outputs must drop before the next clock edge.
    pago_ok = 1'b1;
    tick();
    pago_ok = 1'b0;
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check_output("t6_estado", 8'(estado),       8'd0);
    check_output("t6_abrir",  8'(motor_abrir),  8'd0);
    check_output("t6_cerrar", 8'(motor_cerrar), 8'd0);
    check_output("t6_tal",    8'(talanquera),   8'd0);
    check_output("t6_salidas", salidas,         8'd0);
    check_output("t6_pulses", {5'd0, desborde, timeout, reabre}, 8'd0);
    do_reset();

    apply_stimulus(3000);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Directed check of the overflow pulse in cycle 8, sampled independently of the model.
  initial begin : desborde_probe
    bit seen = 1'b0;
    wait (model_on);
    repeat (700) begin
      @(negedge clk);
      if (desborde && !seen) begin
        seen = 1'b1;
        check_output("t5_desborde_pend", 8'(pendientes), 8'd3);
      end
    end
    check_output("t5_desborde_seen", 8'(seen), 8'd1);
  end

endmodule
